// File: rtl/reorder_buffer_if.sv
// Payload types shared by rename, the reorder buffer and retire, plus the squash interface.
package reorder_buffer_pkg;
    localparam int unsigned ARF_W = 5;
    localparam int unsigned PRF_W = 6;
    localparam int unsigned ID_W  = 8;
    localparam int unsigned PC_W  = 32;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [ARF_W-1:0] rd;
        logic             rd_valid;
    } si_t;

    typedef struct packed {
        si_t              si;
        logic [PRF_W-1:0] prd;
        logic [ID_W-1:0]  id;
    } di_t;

    typedef struct packed {
        logic [ARF_W-1:0] ard;
        logic [PRF_W-1:0] prd;
        logic             needprf2arf;
        logic [ID_W-1:0]  id;
        logic [PC_W-1:0]  pc;
    } rob_entry_t;
endpackage

interface squash_if;
    logic valid;

    modport master (output valid);
    modport slave  (input  valid);
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at the tail, marks entries done on writeback,
// retires done entries from the head one per cycle; squash or reset empties it.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROBSIZE      = 16,
    parameter int unsigned ROB_IDX_BITS = $clog2(ROBSIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  di_t                     di_i,
    input  logic                    di_i_valid,
    output logic                    di_i_ready,
    output logic [ROB_IDX_BITS-1:0] alloc_idx_o,
    input  logic                    wb_valid_i,
    input  logic [ROB_IDX_BITS-1:0] wb_idx_i,
    output rob_entry_t              retire_entry_o,
    output logic                    retire_entry_o_valid,
    output logic [ROB_IDX_BITS:0]   count_o,
    squash_if.slave                 squash_io
);

    localparam int unsigned PTR_W = ROB_IDX_BITS + 1;

    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [ROBSIZE-1:0]      valid_q;
    logic [ROBSIZE-1:0]      done_q;
    rob_entry_t              entries [ROBSIZE];

    logic [ROB_IDX_BITS-1:0] head_idx;
    logic [ROB_IDX_BITS-1:0] tail_idx;
    logic                    empty;
    logic                    full;
    logic                    alloc;
    logic                    retire;
    logic                    wb_hit;

    // Occupancy and handshake decode; wrap bit distinguishes full from empty
    always_comb begin
        head_idx             = head[ROB_IDX_BITS-1:0];
        tail_idx             = tail[ROB_IDX_BITS-1:0];
        empty                = (head == tail);
        full                 = (head_idx == tail_idx) && (head[PTR_W-1] != tail[PTR_W-1]);
        di_i_ready           = !full;
        alloc_idx_o          = tail_idx;
        alloc                = di_i_valid && !full && !squash_io.valid;
        retire               = !empty && done_q[head_idx] && !squash_io.valid;
        wb_hit               = wb_valid_i && valid_q[wb_idx_i] && !squash_io.valid
                               && !(retire && (wb_idx_i == head_idx));
        retire_entry_o_valid = retire;
        retire_entry_o       = entries[head_idx];
        count_o              = tail - head;
    end

    // Pointer and status state; alloc/retire never collide since that needs full or empty
    always_ff @(posedge clk) begin
        if (rst || squash_io.valid) begin
            head    <= '0;
            tail    <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (alloc) begin
                tail              <= tail + PTR_W'(1);
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
            end
            if (wb_hit) begin
                done_q[wb_idx_i] <= 1'b1;
            end
            if (retire) begin
                head              <= head + PTR_W'(1);
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
            end
        end
    end

    // Payload storage, written only on allocation
    always_ff @(posedge clk) begin
        if (alloc) begin
            entries[tail_idx] <= '{ard:         di_i.si.rd,
                                   prd:         di_i.prd,
                                   needprf2arf: di_i.si.rd_valid,
                                   id:          di_i.id,
                                   pc:          di_i.si.pc};
        end
    end

    // A writeback can never target the slot being allocated in the same cycle
    always_ff @(posedge clk) begin
        if (!rst && !squash_io.valid && alloc && wb_valid_i) begin
            assert (wb_idx_i != tail_idx)
                else $error("writeback to entry %0d in its allocation cycle", wb_idx_i);
        end
    end

endmodule
